spi_master_ctrl: RTL and testbench

//  Master-side sequencer for the SPI slave link: accepts bytes from a local requester
//  (valid/ready), drives ss_n/sck/mosi in SPI mode 0 (CPOL=0, CPHA=0), samples miso
//  and returns one received byte per transfer. Sits between system logic and spi_slave.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 43 ++++
 rtl/spi_master_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state encoding and SPI mode constants for the SPI master controller.
package spi_pkg;

  localparam int   SPI_DATA_W = 8;
  localparam logic SPI_CPOL   = 1'b0;
  localparam logic SPI_CPHA   = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  // The requester may hand over a byte only while waiting for a frame or a beat.
  function automatic logic is_ready_state(input spi_state_e s);
    return (s == IDLE) || (s == GAP);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for sck: counts CLK_DIV cycles while enabled and toggles sck,
// reporting the leading (rise) and trailing (fall) edge one cycle before sck moves.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic             sck_r;
  logic             tick_s;

  assign tick_s   = en && (cnt_r == CNT_W'(CLK_DIV - 1));
  assign sck_rise = tick_s && (sck_r == SPI_CPOL);
  assign sck_fall = tick_s && (sck_r != SPI_CPOL);
  assign sck      = sck_r;

  // Divider counter and sck phase; both snap back to idle whenever shifting stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      sck_r <= SPI_CPOL;
    end else if (!en) begin
      cnt_r <= {CNT_W{1'b0}};
      sck_r <= SPI_CPOL;
    end else if (tick_s) begin
      cnt_r <= {CNT_W{1'b0}};
      sck_r <= ~sck_r;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer with multi-beat frames (ss_n held low until a last beat).
// Build option: define SPI_LOOPBACK_EN to sample the internal mosi instead of the miso pin.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W,
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              ss_n,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SET_W = $clog2(SS_SETUP + 1);

  spi_state_e        state_r;
  spi_state_e        state_s;
  logic [DATA_W-1:0] tx_sr_r;
  logic [DATA_W-1:0] rx_sr_r;
  logic [DATA_W-1:0] rx_data_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [SET_W-1:0]  setup_cnt_r;
  logic              last_r;
  logic              ss_n_r;
  logic              mosi_r;
  logic              rx_valid_r;
  logic              busy_r;
  logic              tx_ready_r;
  logic              accept_s;
  logic              sck_s;
  logic              sck_rise_s;
  logic              sck_fall_s;
  logic              sample_edge_s;
  logic              shift_edge_s;
  logic              sample_bit_s;
  logic              last_bit_s;
  logic              setup_done_s;

  assign accept_s     = tx_valid && tx_ready_r;
  assign last_bit_s   = (bit_cnt_r == BIT_W'(DATA_W - 1));
  assign setup_done_s = (setup_cnt_r == SET_W'(SS_SETUP - 1));

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_r == SHIFT),
    .sck      (sck_s),
    .sck_rise (sck_rise_s),
    .sck_fall (sck_fall_s)
  );

  // Mode 0: capture on the leading edge, launch the next bit on the trailing edge.
  assign sample_edge_s = (SPI_CPHA == 1'b0) ? sck_rise_s : sck_fall_s;
  assign shift_edge_s  = (SPI_CPHA == 1'b0) ? sck_fall_s : sck_rise_s;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso_s;
  assign unused_miso_s = miso;
  assign sample_bit_s  = mosi_r;
`else
  assign sample_bit_s  = miso;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a beat inside a frame re-enters SHIFT from GAP without SETUP.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = SETUP;
        else          state_s = IDLE;
      end
      SETUP: begin
        if (setup_done_s) state_s = SHIFT;
        else              state_s = SETUP;
      end
      SHIFT: begin
        if (shift_edge_s && last_bit_s) state_s = DONE;
        else                            state_s = SHIFT;
      end
      DONE: begin
        if (last_r) state_s = IDLE;
        else        state_s = GAP;
      end
      GAP: begin
        if (accept_s) state_s = SHIFT;
        else          state_s = GAP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake and status flags, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      rx_valid_r <= 1'b0;
    end else begin
      tx_ready_r <= is_ready_state(state_s);
      busy_r     <= (state_s != IDLE);
      rx_valid_r <= (state_s == DONE);
    end
  end

  // SETUP dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setup_cnt_r <= {SET_W{1'b0}};
    end else if (state_r == SETUP) begin
      setup_cnt_r <= setup_cnt_r + SET_W'(1);
    end else begin
      setup_cnt_r <= {SET_W{1'b0}};
    end
  end

  // Transmit path: latch the beat on accept, then walk MSB-first on trailing edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr_r   <= {DATA_W{1'b0}};
      mosi_r    <= 1'b0;
      last_r    <= 1'b0;
      bit_cnt_r <= {BIT_W{1'b0}};
    end else if (accept_s) begin
      tx_sr_r   <= tx_data;
      mosi_r    <= tx_data[DATA_W-1];
      last_r    <= tx_last;
      bit_cnt_r <= {BIT_W{1'b0}};
    end else if (shift_edge_s) begin
      tx_sr_r   <= {tx_sr_r[DATA_W-2:0], 1'b0};
      mosi_r    <= tx_sr_r[DATA_W-2];
      bit_cnt_r <= bit_cnt_r + BIT_W'(1);
    end
  end

  // Receive path: shift in on leading edges, publish as the beat completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr_r   <= {DATA_W{1'b0}};
      rx_data_r <= {DATA_W{1'b0}};
    end else begin
      if (sample_edge_s) begin
        rx_sr_r <= {rx_sr_r[DATA_W-2:0], sample_bit_s};
      end
      if (state_s == DONE) begin
        rx_data_r <= rx_sr_r;
      end
    end
  end

  // Slave select: drops on the first accepted beat, rises only after a last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_r <= 1'b1;
    end else if (accept_s) begin
      ss_n_r <= 1'b0;
    end else if ((state_r == DONE) && last_r) begin
      ss_n_r <= 1'b1;
    end
  end

  assign tx_ready = tx_ready_r;
  assign busy     = busy_r;
  assign rx_valid = rx_valid_r;
  assign rx_data  = rx_data_r;
  assign ss_n     = ss_n_r;
  assign sck      = sck_s;
  assign mosi     = mosi_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: mode-0 slave model, accept-time scoreboard,
// table of beats/frames plus hand sequences for held tx_valid and mid-transfer reset.
module tb_spi_master_ctrl;

  localparam int DATA_W   = 8;
  localparam int CLK_DIV  = 4;
  localparam int SS_SETUP = 2;
  localparam int LAT_IDLE = 1 + SS_SETUP + 2 * DATA_W * CLK_DIV;
  localparam int LAT_GAP  = 1 + 2 * DATA_W * CLK_DIV;
  localparam int NVEC     = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       miso = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, busy, ss_n, sck, mosi;
  logic [7:0] rx_data;

  spi_master_ctrl #(
    .DATA_W   (DATA_W),
    .CLK_DIV  (CLK_DIV),
    .SS_SETUP (SS_SETUP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .ss_n     (ss_n),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx_exp;
    int         acc_cyc;
    int         lat;
    logic       last;
  } sb_t;

  typedef struct {
    logic [7:0] tx;
    logic       last;
    logic [7:0] slv;
  } vec_t;

  sb_t        sb_q[$];
  sb_t        mon_e;
  logic [7:0] slave_q[$];
  logic [7:0] s_sr = 8'h00;
  int         s_cnt = 0;
  vec_t       vecs[NVEC];

  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         rx_seen = 0;
  int         rises = 0;
  int         ss_rises = 0;
  int         base_rx = 0;
  int         frame_beats = 0;
  logic       frame_open = 1'b0;
  logic       ss_chk = 1'b0;
  logic       ss_exp = 1'b1;
  logic [7:0] mosi_sr = 8'h00;
  logic [7:0] cur_slv = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] slv);
    logic [7:0] r;
    r = slv;
`ifdef SPI_LOOPBACK_EN
    r = tx;
`endif
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 slave: first bit on ss_n fall, next bit after each sck fall, new byte every 8.
  always @(negedge ss_n) begin
    s_cnt = 0;
    if (slave_q.size() > 0) s_sr = slave_q.pop_front();
    else s_sr = 8'h00;
    miso = s_sr[7];
  end

  always @(negedge sck) begin
    if (ss_n === 1'b0) begin
      s_cnt++;
      if (s_cnt == 8) begin
        s_cnt = 0;
        if (slave_q.size() > 0) s_sr = slave_q.pop_front();
        else s_sr = 8'h00;
      end else begin
        s_sr = {s_sr[6:0], 1'b0};
      end
      miso = s_sr[7];
    end
  end

  always @(posedge sck) begin
    mosi_sr = {mosi_sr[6:0], mosi};
    rises++;
  end

  always @(posedge ss_n) ss_rises++;

  // Scoreboard: push at accept, pop and compare on rx_valid.
  always @(negedge clk) begin
    #1;
    if (ss_chk) begin
      check("ss_n_after_done", {31'd0, ss_n}, {31'd0, ss_exp});
      ss_chk = 1'b0;
    end
    if (rst_n && tx_valid && tx_ready) begin
      mon_e.tx      = tx_data;
      mon_e.rx_exp  = exp_rx(tx_data, cur_slv);
      mon_e.acc_cyc = cyc;
      mon_e.lat     = frame_open ? LAT_GAP : LAT_IDLE;
      mon_e.last    = tx_last;
      frame_open    = !tx_last;
      sb_q.push_back(mon_e);
    end
    if (rx_valid) begin
      rx_seen++;
      if (sb_q.size() == 0) begin
        check("rx_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.rx_exp});
        check("mosi_bits", {24'd0, mosi_sr}, {24'd0, mon_e.tx});
        check("latency", cyc - mon_e.acc_cyc, mon_e.lat);
        ss_chk = 1'b1;
        ss_exp = mon_e.last;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic last, input logic [7:0] slv);
    int n = 0;
    @(negedge clk);
    cur_slv  = slv;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", {31'd0, n < 400}, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_seen < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rx_in_time", {31'd0, rx_seen >= target}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{tx: 8'hA5, last: 1'b1, slv: 8'h3C};
    vecs[1] = '{tx: 8'h11, last: 1'b0, slv: 8'h5A};
    vecs[2] = '{tx: 8'h22, last: 1'b0, slv: 8'hC3};
    vecs[3] = '{tx: 8'h33, last: 1'b1, slv: 8'h0F};
    vecs[4] = '{tx: 8'hFF, last: 1'b1, slv: 8'h00};
    vecs[5] = '{tx: 8'h00, last: 1'b1, slv: 8'hFF};
    vecs[6] = '{tx: 8'hC3, last: 1'b1, slv: 8'h00};

    repeat (3) @(negedge clk);
    check("rst_ss_n", {31'd0, ss_n}, 32'd1);
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      if (i == 0 || vecs[i-1].last) begin
        frame_beats = 0;
        for (int j = i; j < NVEC; j++) begin
          slave_q.push_back(vecs[j].slv);
          frame_beats++;
          if (vecs[j].last) break;
        end
        rises    = 0;
        ss_rises = 0;
        base_rx  = rx_seen;
      end
      send(vecs[i].tx, vecs[i].last, vecs[i].slv);
      if (vecs[i].last) begin
        wait_rx(base_rx + frame_beats);
        repeat (3) @(negedge clk);
        check("frame_sck_rises", rises, 8 * frame_beats);
        check("frame_rx_pulses", rx_seen - base_rx, frame_beats);
        check("frame_ss_rises", ss_rises, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
      end
    end

    // tx_valid held with other data during a transfer must be ignored
    slave_q.push_back(8'h96);
    rises   = 0;
    base_rx = rx_seen;
    send(8'h5C, 1'b1, 8'h96);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hE7;
    tx_last  = 1'b0;
    check("hold_busy", {31'd0, busy}, 32'd1);
    check("hold_tx_ready", {31'd0, tx_ready}, 32'd0);
    repeat (40) @(negedge clk);
    tx_valid = 1'b0;
    wait_rx(base_rx + 1);
    repeat (3) @(negedge clk);
    check("hold_sck_rises", rises, 32'd8);
    check("hold_rx_pulses", rx_seen - base_rx, 32'd1);

    // reset after the 4th sck rise
    begin
      int n = 0;
      slave_q.push_back(8'h81);
      rises   = 0;
      base_rx = rx_seen;
      send(8'h3C, 1'b1, 8'h81);
      while (rises < 4 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reach_4_rises", rises, 32'd4);
      check("pre_rst_ss_n", {31'd0, ss_n}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_ss_n", {31'd0, ss_n}, 32'd1);
      check("midrst_sck", {31'd0, sck}, 32'd0);
      check("midrst_mosi", {31'd0, mosi}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
      sb_q.delete();
      slave_q.delete();
      frame_open = 1'b0;
      ss_chk     = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      check("no_rx_after_rst", rx_seen - base_rx, 32'd0);
    end

    slave_q.push_back(8'h9E);
    rises   = 0;
    base_rx = rx_seen;
    send(8'h69, 1'b1, 8'h9E);
    wait_rx(base_rx + 1);
    repeat (3) @(negedge clk);
    check("post_rst_sck_rises", rises, 32'd8);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
